alu_ctrl_stage: RTL

Registered, flow-controlled ALU-control stage for the CPU datapath, sitting between instruction decode and execute. Translates the main-decoder ALUOp plus funct/opcode into a 4-bit `ALU_*` operation, flags illegal encodings, and sequences multi-cycle multiply/divide by stalling upstream for a parametrised latency. Successor to the combinational ALU-control decoder: adds an I-type decode mode, a valid/ready pipeline register, a flush, and an MD busy counter.

---
 rtl/alu_ctrl_stage_if.sv | 30 +++
 rtl/alu_ctrl_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage_if.sv
// Handshake and decode bus between instruction decode, the ALU-control
// stage and execute. The stage itself connects through the slave modport.
interface alu_ctrl_stage_if #(
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_sel;
  logic [5:0]      funct;
  logic [5:0]      opcode;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] alu_op;
  logic [1:0]      md_op;
  logic            md_signed;
  logic            illegal;
  logic            busy;
  logic            md_done;

  modport master (
    output in_valid, alu_sel, funct, opcode, flush, out_ready,
    input  in_ready, out_valid, alu_op, md_op, md_signed, illegal, busy, md_done
  );

  modport slave (
    input  in_valid, alu_sel, funct, opcode, flush, out_ready,
    output in_ready, out_valid, alu_op, md_op, md_signed, illegal, busy, md_done
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decodes ALUOp/funct/opcode into an ALU
// operation, flags illegal encodings and stalls upstream while a
// multiply/divide occupies the execute unit.
module alu_ctrl_stage #(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_ctrl_stage_if.slave   bus
);

  localparam logic [OP_W-1:0] ALU_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] ALU_XOR = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] ALU_SLT = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] ALU_SLL = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] ALU_SRL = OP_W'(4'b1001);
  localparam logic [OP_W-1:0] ALU_SRA = OP_W'(4'b1010);
  localparam logic [OP_W-1:0] ALU_NOR = OP_W'(4'b1100);

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [1:0]      md_op_q, md_op_d;
  logic            md_signed_q, md_signed_d;
  logic            illegal_q, illegal_d;
  logic [5:0]      cnt_q, cnt_d;

  logic [OP_W-1:0] dec_alu_op;
  logic [1:0]      dec_md_op;
  logic            dec_md_signed;
  logic            dec_illegal;
  logic            in_ready;
  logic            accept;

  assign in_ready = (!out_valid_q || bus.out_ready) && (cnt_q == 6'd0) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // Translate ALUOp plus funct/opcode into the ALU operation and MD class.
  always_comb begin
    dec_alu_op    = ALU_ADD;
    dec_md_op     = MD_NONE;
    dec_md_signed = 1'b0;
    dec_illegal   = 1'b0;
    case (bus.alu_sel)
      2'b00: dec_alu_op = ALU_ADD;
      2'b01: dec_alu_op = ALU_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100100: dec_alu_op = ALU_AND;
          6'b100101: dec_alu_op = ALU_OR;
          6'b100110: dec_alu_op = ALU_XOR;
          6'b100111: dec_alu_op = ALU_NOR;
          6'b100000, 6'b100001: dec_alu_op = ALU_ADD;
          6'b100010, 6'b100011: dec_alu_op = ALU_SUB;
          6'b101010: dec_alu_op = ALU_SLT;
          6'b000000: dec_alu_op = ALU_SLL;
          6'b000010: dec_alu_op = ALU_SRL;
          6'b000011: dec_alu_op = ALU_SRA;
          6'b011000, 6'b011001: begin
            dec_md_op     = MD_MUL;
            dec_md_signed = ~bus.funct[0];
          end
          6'b011010, 6'b011011: begin
            dec_md_op     = MD_DIV;
            dec_md_signed = ~bus.funct[0];
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (bus.opcode)
          6'b001100: dec_alu_op = ALU_AND;
          6'b001101: dec_alu_op = ALU_OR;
          6'b001110: dec_alu_op = ALU_XOR;
          6'b001000, 6'b001001: dec_alu_op = ALU_ADD;
          6'b001010: dec_alu_op = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Next state of the output register and the MD busy counter.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    md_op_d     = md_op_q;
    md_signed_d = md_signed_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      cnt_d       = 6'd0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_alu_op;
      md_op_d     = dec_md_op;
      md_signed_d = dec_md_signed;
      illegal_d   = dec_illegal;
      if (dec_md_op == MD_MUL) begin
        cnt_d = MUL_LOAD;
      end else if (dec_md_op == MD_DIV) begin
        cnt_d = DIV_LOAD;
      end
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (cnt_q != 6'd0) begin
        cnt_d = cnt_q - 6'd1;
      end
    end
  end

  // Output register and counter; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
      md_op_q     <= MD_NONE;
      md_signed_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= 6'd0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      md_op_q     <= md_op_d;
      md_signed_q <= md_signed_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.md_op     = md_op_q;
  assign bus.md_signed = md_signed_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (cnt_q != 6'd0);
  assign bus.md_done   = (cnt_q == 6'd1) && !bus.flush;

endmodule
